mptw_request_issuer: RTL

Initiator end of the MPT walk pipeline: accepts permission-check requests from the requester (IOMMU/hart side) and packs each into an `mptw_transaction_t`. Buffers requests in a small FIFO and drives them onto the pipeline data port consumed by the fetch stage, tagging each with a rolling transaction ID. Enforces a credit limit on in-flight transactions, retired by completion pulses from the pipeline tail.

---
 rtl/mptw_request_issuer_if.sv | 24 ++
 rtl/mptw_request_issuer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mptw_request_issuer_if.sv
// Request and issue handshake bundle for mptw_request_issuer.
// master = issuer side, slave = requester plus fetch-stage side.
interface mptw_request_issuer_if #(
    parameter int unsigned DATA_WIDTH = 134
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [63:0]           req_mmpt_i;
    logic [63:0]           req_spa_i;
    logic [1:0]            req_acc_i;
    logic [DATA_WIDTH-1:0] issue_master_data;
    logic                  issue_master_valid;
    logic                  issue_master_ready;

    modport master (
        input  req_valid_i, req_mmpt_i, req_spa_i, req_acc_i, issue_master_ready,
        output req_ready_o, issue_master_data, issue_master_valid
    );

    modport slave (
        output req_valid_i, req_mmpt_i, req_spa_i, req_acc_i, issue_master_ready,
        input  req_ready_o, issue_master_data, issue_master_valid
    );
endinterface

// File: rtl/mptw_request_issuer.sv
// MPT walk initiator: buffers permission-check requests, tags them with a rolling ID and issues
// them under a credit limit. Optional BARE-mode local completion via MPTW_ISSUER_BARE_BYPASS_EN.
module mptw_request_issuer #(
    parameter int unsigned ID_WIDTH                   = 4,
    parameter int unsigned PIPELINE_MASTER_DATA_WIDTH = 130 + ID_WIDTH,
    parameter int unsigned FIFO_DEPTH                 = 2,
    parameter int unsigned MAX_OUTSTANDING            = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    mptw_request_issuer_if.master        bus_io,
    input  logic                         flush_i,
    input  logic                         rsp_valid_i,
    output logic [3:0]                   outstanding_o,
    output logic                         proto_err_o,
    output logic                         bypass_valid_o,
    output logic [ID_WIDTH-1:0]          bypass_id_o
);

    typedef struct packed {
        logic [63:0]         mmpt;
        logic [63:0]         spa;
        logic [1:0]          acc;
        logic [ID_WIDTH-1:0] id;
    } mptw_transaction_t;

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_credits
        $error("MAX_OUTSTANDING must be in 1..15");
    end

    mptw_transaction_t fifo_q [FIFO_DEPTH];
    mptw_transaction_t new_entry;

    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [ID_WIDTH-1:0] next_id_q, next_id_d;
    logic [3:0]          outstanding_q, outstanding_d;
    logic                proto_err_q, proto_err_d;

    logic req_ready;
    logic accept;
    logic bypass;
    logic enq;
    logic issue_valid;
    logic pop;
    logic retire;

    // Ready comes from the registered count only, so a full FIFO never pops through.
    assign req_ready   = count_q < CntW'(FIFO_DEPTH);
    assign accept      = bus_io.req_valid_i && req_ready && !flush_i;
    assign enq         = accept && !bypass;
    assign issue_valid = (count_q != '0) && (outstanding_q < 4'(MAX_OUTSTANDING));
    assign pop         = issue_valid && bus_io.issue_master_ready && !flush_i;
    assign retire      = rsp_valid_i && (outstanding_q != 4'd0);

    assign new_entry = '{
        mmpt: bus_io.req_mmpt_i,
        spa:  bus_io.req_spa_i,
        acc:  bus_io.req_acc_i,
        id:   next_id_q
    };

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        next_id_d     = next_id_q;
        outstanding_d = outstanding_q;
        proto_err_d   = proto_err_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({enq, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end

        if (accept) begin
            next_id_d = next_id_q + ID_WIDTH'(1);
        end

        // Flush leaves credits alone: already-issued transactions still retire normally.
        unique case ({pop, retire})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase

        if (rsp_valid_i && (outstanding_q == 4'd0)) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            next_id_q     <= '0;
            outstanding_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            next_id_q     <= next_id_d;
            outstanding_q <= outstanding_d;
            proto_err_q   <= proto_err_d;
        end
    end

    // Storage is cleared on reset so the issue bus reads as zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (enq) begin
            fifo_q[wr_ptr_q] <= new_entry;
        end
    end

`ifdef MPTW_ISSUER_BARE_BYPASS_EN
    localparam logic [3:0] BareMode = 4'd0;

    logic                bypass_valid_q, bypass_valid_d;
    logic [ID_WIDTH-1:0] bypass_id_q, bypass_id_d;

    // BARE requests complete locally: they consume an ID but no FIFO slot or credit.
    assign bypass = accept && (bus_io.req_mmpt_i[63:60] == BareMode);

    always_comb begin
        bypass_valid_d = bypass;
        bypass_id_d    = bypass ? next_id_q : bypass_id_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bypass_valid_q <= 1'b0;
            bypass_id_q    <= '0;
        end else begin
            bypass_valid_q <= bypass_valid_d;
            bypass_id_q    <= bypass_id_d;
        end
    end

    assign bypass_valid_o = bypass_valid_q;
    assign bypass_id_o    = bypass_id_q;
`else
    assign bypass         = 1'b0;
    assign bypass_valid_o = 1'b0;
    assign bypass_id_o    = '0;
`endif

    assign bus_io.req_ready_o        = req_ready;
    assign bus_io.issue_master_valid = issue_valid;
    assign bus_io.issue_master_data  = PIPELINE_MASTER_DATA_WIDTH'(fifo_q[rd_ptr_q]);
    assign outstanding_o             = outstanding_q;
    assign proto_err_o               = proto_err_q;

    // A stalled issue must hold both valid and data until accepted or flushed.
    a_issue_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (issue_valid && !bus_io.issue_master_ready && !flush_i)
        |=> (issue_valid && $stable(bus_io.issue_master_data)));

    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CntW'(FIFO_DEPTH));

endmodule
